// File: rtl/xform_pkg.sv
// Shared types and widths for the transform-engine command scheduler.
package xform_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'd0,
        OP_WRITE = 4'd1,
        OP_READ  = 4'd2,
        OP_START = 4'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RDCAP,
        ST_WAIT_DONE,
        ST_ACK,
        ST_RESP
    } state_e;

    // Codes above OP_START are reserved and must never reach the engine.
    function automatic logic op_legal(input logic [OP_W-1:0] code);
        return (code <= OP_W'(OP_START));
    endfunction

endpackage

// File: rtl/xform_cmd_sched_if.sv
// Requester command/response bus plus engine register/op bus.
// master: the environment (requesters and engine); slave: the scheduler.
interface xform_cmd_sched_if
    import xform_pkg::*;
#(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][OP_W-1:0]   req_op;
    logic [NREQ-1:0][ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]           rsp_data;
    logic                        rsp_err;
    logic [ADDR_W-1:0]           addr;
    logic [DATA_W-1:0]           wdata;
    logic [OP_W-1:0]             op;
    logic                        int_ack;
    logic [DATA_W-1:0]           rdata;
    logic                        done_int;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rdata, done_int,
        input  req_ready, rsp_valid, rsp_data, rsp_err, addr, wdata, op, int_ack
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rdata, done_int,
        output req_ready, rsp_valid, rsp_data, rsp_err, addr, wdata, op, int_ack
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or above ptr,
// wrapping around; no grant when en is low.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan candidates starting from the pointer; the first hit wins.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        vld      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDX_W'(cand);
            if (en && !vld && req[cand_idx]) begin
                vld           = 1'b1;
                idx           = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xform_cmd_sched.sv
// Shares one transform engine among NREQ requesters: round-robin grant,
// one command in flight, engine bus sequencing, done/ack handshake with
// timeout, and a one-cycle response pulse back to the granted requester.
module xform_cmd_sched
    import xform_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input logic              clk,
    input logic              rst_b,
    xform_cmd_sched_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, gidx_q, arb_idx, ptr_nxt;
    logic [NREQ-1:0]    arb_gnt;
    logic               arb_vld, arb_en;
    logic [OP_W-1:0]    cmd_op_q;
    logic [ADDR_W-1:0]  cmd_addr_q;
    logic [DATA_W-1:0]  cmd_wdata_q;
    logic [TO_W-1:0]    cnt_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_err_q;
    logic               cmd_legal;
    logic               cnt_last;

    assign cmd_legal = op_legal(cmd_op_q);
    assign cnt_last  = (cnt_q == TO_W'(TIMEOUT - 1));
    assign ptr_nxt   = (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; arbitration is only enabled while idle.
    always_comb begin
        state_d = state_q;
        arb_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
                if (arb_vld) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!cmd_legal) begin
                    state_d = ST_RESP;
                end else begin
                    case (cmd_op_q)
                        OP_READ:  state_d = ST_RDCAP;
                        OP_START: state_d = ST_WAIT_DONE;
                        default:  state_d = ST_RESP;
                    endcase
                end
            end
            ST_RDCAP: state_d = ST_RESP;
            ST_WAIT_DONE: begin
                if (bus.done_int)  state_d = ST_ACK;
                else if (cnt_last) state_d = ST_RESP;
            end
            ST_ACK: begin
                if (!bus.done_int) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Command latch, RR pointer, timeout counter and response registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ptr_q       <= '0;
            gidx_q      <= '0;
            cmd_op_q    <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (arb_vld) begin
                ptr_q       <= ptr_nxt;
                gidx_q      <= arb_idx;
                cmd_op_q    <= bus.req_op[arb_idx];
                cmd_addr_q  <= bus.req_addr[arb_idx];
                cmd_wdata_q <= bus.req_wdata[arb_idx];
                rsp_data_q  <= '0;
                rsp_err_q   <= 1'b0;
            end
            if (state_q == ST_ISSUE) begin
                cnt_q <= '0;
                if (!cmd_legal) rsp_err_q <= 1'b1;
            end
            // Engine presents read data the cycle after the READ issue.
            if (state_q == ST_RDCAP) begin
                rsp_data_q <= bus.rdata;
            end
            if (state_q == ST_WAIT_DONE && !bus.done_int) begin
                if (cnt_last) rsp_err_q <= 1'b1;
                else          cnt_q     <= cnt_q + 1'b1;
            end
        end
    end

    // Outputs decoded from state; the engine sees NOP outside a legal issue.
    always_comb begin
        bus.req_ready = arb_gnt;
        bus.op        = OP_NOP;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.int_ack   = 1'b0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.rsp_err   = 1'b0;
        if (state_q == ST_ISSUE && cmd_legal) begin
            bus.op    = cmd_op_q;
            bus.addr  = cmd_addr_q;
            bus.wdata = cmd_wdata_q;
        end
        if (state_q == ST_ACK) begin
            bus.int_ack = 1'b1;
        end
        if (state_q == ST_RESP) begin
            bus.rsp_valid = NREQ'(1) << gidx_q;
            bus.rsp_data  = rsp_data_q;
            bus.rsp_err   = rsp_err_q;
        end
    end

endmodule

// File: tb/tb_xform_cmd_sched.sv
// Directed bench for xform_cmd_sched with two requesters and a short timeout.
module tb_xform_cmd_sched;
    import xform_pkg::*;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;

    logic clk;
    logic rst_b;
    int   total;
    int   bad;

    xform_cmd_sched_if #(.NREQ(NREQ)) bus ();

    xform_cmd_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic quiet;
        logic [1:0] exp_g;
        total = 0;
        bad   = 0;
        rst_b = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rdata     = '0;
        bus.done_int  = 1'b0;

        // Reset state.
        #2;
        chk("rst_op", bus.op, OP_NOP);
        chk("rst_ack", bus.int_ack, 0);
        chk("rst_rsp", bus.rsp_valid, 0);
        chk("rst_addr", bus.addr, 0);
        cyc();
        cyc();
        rst_b = 1'b1;
        #1;

        // WRITE from requester 0.
        bus.req_valid = 2'b01;
        bus.req_op[0] = 4'd1;
        bus.req_addr[0] = 6'h04;
        bus.req_wdata[0] = 32'hDEADBEEF;
        #1;
        chk("wr_ready", bus.req_ready, 2'b01);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("wr_op", bus.op, 4'd1);
        chk("wr_addr", bus.addr, 6'h04);
        chk("wr_wdata", bus.wdata, 32'hDEADBEEF);
        chk("wr_norsp", bus.rsp_valid, 0);
        cyc();
        chk("wr_rsp", bus.rsp_valid, 2'b01);
        chk("wr_err", bus.rsp_err, 0);
        chk("wr_data", bus.rsp_data, 0);
        cyc();
        chk("wr_idle", bus.rsp_valid, 0);

        // READ from requester 1; rdata only valid the cycle after issue.
        bus.req_valid = 2'b10;
        bus.req_op[1] = 4'd2;
        bus.req_addr[1] = 6'h08;
        #1;
        chk("rd_ready", bus.req_ready, 2'b10);
        cyc();
        bus.req_valid = '0;
        bus.rdata = 32'hBAD0BAD0;
        #1;
        chk("rd_op", bus.op, 4'd2);
        chk("rd_addr", bus.addr, 6'h08);
        cyc();
        bus.rdata = 32'h12345678;
        #1;
        chk("rd_capop", bus.op, OP_NOP);
        cyc();
        bus.rdata = 32'h0;
        #1;
        chk("rd_rsp", bus.rsp_valid, 2'b10);
        chk("rd_data", bus.rsp_data, 32'h12345678);
        chk("rd_err", bus.rsp_err, 0);
        cyc();

        // Both requesters busy: grants must alternate starting at 0.
        bus.req_op[0] = 4'd1;
        bus.req_op[1] = 4'd1;
        bus.req_addr[0] = 6'h10;
        bus.req_addr[1] = 6'h21;
        bus.req_valid = 2'b11;
        for (int n = 0; n < 8; n++) begin
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("rr_grant", bus.req_ready, exp_g);
            cyc();
            chk("rr_addr", bus.addr, (n % 2 == 0) ? 6'h10 : 6'h21);
            cyc();
            chk("rr_rsp", bus.rsp_valid, exp_g);
            cyc();
        end
        bus.req_valid = '0;
        cyc();

        // START from requester 0, done_int raised 10 cycles after grant.
        bus.req_op[0] = 4'd3;
        bus.req_valid = 2'b01;
        #1;
        chk("st_ready", bus.req_ready, 2'b01);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("st_op", bus.op, 4'd3);
        quiet = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            cyc();
            if (bus.int_ack || bus.rsp_valid != 0 || bus.op != 0) quiet = 1'b1;
        end
        chk("st_wait_quiet", quiet, 0);
        cyc();
        bus.done_int = 1'b1;
        cyc();
        chk("st_ack1", bus.int_ack, 1);
        cyc();
        chk("st_ack2", bus.int_ack, 1);
        bus.done_int = 1'b0;
        cyc();
        chk("st_rsp", bus.rsp_valid, 2'b01);
        chk("st_err", bus.rsp_err, 0);
        chk("st_ackoff", bus.int_ack, 0);
        cyc();

        // START from requester 1 with no done_int: timeout after 16 waits.
        bus.req_op[1] = 4'd3;
        bus.req_valid = 2'b10;
        #1;
        chk("to_ready", bus.req_ready, 2'b10);
        cyc();
        bus.req_valid = '0;
        quiet = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            cyc();
            if (bus.int_ack || bus.rsp_valid != 0) quiet = 1'b1;
        end
        chk("to_quiet", quiet, 0);
        cyc();
        chk("to_rsp", bus.rsp_valid, 2'b10);
        chk("to_err", bus.rsp_err, 1);
        chk("to_ack", bus.int_ack, 0);
        cyc();

        // Illegal op 0xA with a stray done_int: engine stays NOP, no ack.
        bus.req_op[0] = 4'hA;
        bus.done_int = 1'b1;
        bus.req_valid = 2'b01;
        #1;
        chk("il_ready", bus.req_ready, 2'b01);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("il_op", bus.op, OP_NOP);
        cyc();
        chk("il_rsp", bus.rsp_valid, 2'b01);
        chk("il_err", bus.rsp_err, 1);
        chk("il_ack", bus.int_ack, 0);
        cyc();
        bus.done_int = 1'b0;

        // Reset during WAIT_DONE: outputs clear and no response follows.
        bus.req_op[1] = 4'd3;
        bus.req_valid = 2'b10;
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();
        #3;
        rst_b = 1'b0;
        #1;
        chk("rw_op", bus.op, OP_NOP);
        chk("rw_rsp", bus.rsp_valid, 0);
        chk("rw_err", bus.rsp_err, 0);
        cyc();
        rst_b = 1'b1;
        quiet = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (bus.rsp_valid != 0) quiet = 1'b1;
        end
        chk("rw_norsp", quiet, 0);

        // Reset during ACK drops int_ack without a clock edge.
        bus.req_op[0] = 4'd3;
        bus.req_valid = 2'b01;
        cyc();
        bus.req_valid = '0;
        bus.done_int = 1'b1;
        cyc();
        chk("ra_wait", bus.int_ack, 0);
        cyc();
        chk("ra_ack", bus.int_ack, 1);
        #3;
        rst_b = 1'b0;
        #1;
        chk("ra_ackoff", bus.int_ack, 0);
        chk("ra_op", bus.op, OP_NOP);
        bus.done_int = 1'b0;
        cyc();
        rst_b = 1'b1;
        #1;

        // Pointer returns to 0 after reset.
        bus.req_op[0] = 4'd1;
        bus.req_op[1] = 4'd1;
        bus.req_valid = 2'b11;
        #1;
        chk("rp_grant", bus.req_ready, 2'b01);
        cyc();
        bus.req_valid = '0;
        cyc();
        chk("rp_rsp", bus.rsp_valid, 2'b01);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
